// File: rtl/mux_f_cfg_pkg.sv
// Shared definitions for the F7/F8 mux configuration path.
//   state_t   : loader FSM state encoding
//   cfg_width : total committed config width for a given slice count/mux depth,
//               the same math used when sizing the mux_f_slice instances
package mux_f_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    function automatic int cfg_width(input int mux_level, input int num_slices);
        return mux_level * num_slices;
    endfunction

endpackage

// File: rtl/mux_f_cfg_shifter.sv
// Serial-in shift register with bit counter for the config loader.
// Ports:
//   clk, rst_n     : clock / asynchronous active-low reset
//   clear          : zero the shift register and the bit count
//   shift          : accept bit_in this cycle
//   bit_in         : serial bit, MSB of the full word first
//   next_word      : register contents with bit_in appended (value after a shift)
//   full_on_shift  : a shift this cycle fills the register (count == CFG_W-1)
module mux_f_cfg_shifter #(
    parameter int CFG_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    output logic [CFG_W-1:0] next_word,
    output logic             full_on_shift
);

    localparam int CNT_W = $clog2(CFG_W + 1);

    logic [CFG_W-1:0] sr;
    logic [CNT_W-1:0] count;

    assign next_word     = {sr[CFG_W-2:0], bit_in};
    assign full_on_shift = (count == CNT_W'(CFG_W - 1));

    // The loader leaves LOAD on the filling shift, so count stops at CFG_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            count <= '0;
        end else if (clear) begin
            sr    <= '0;
            count <= '0;
        end else if (shift) begin
            sr    <= next_word;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_f_config_loader.sv
// Serial configuration loader for the F7/F8 mux slices of a CLB.
// Assembles a bit-serial stream into one MUX_LEVEL-bit select word per slice and
// commits all of them together, framed by a setup cycle before and a hold cycle
// after the single-cycle cen pulse.
// Ports:
//   cclk, crst_n : config clock / asynchronous active-low reset
//   start        : begin a load (only from IDLE)
//   abort        : cancel a load in progress; committed config is untouched
//   bit_valid    : bit_in valid
//   bit_in       : serial config bit, MSB first
//   bit_ready    : a bit is accepted this cycle (LOAD only)
//   cfg_out      : committed config, slice s at [s*MUX_LEVEL +: MUX_LEVEL]
//   cen          : one-cycle config enable to the slices
//   busy         : loader not idle
//   done         : one-cycle pulse after a commit
//   err          : one-cycle pulse after an aborted load
module mux_f_config_loader
    import mux_f_cfg_pkg::*;
#(
    parameter int MUX_LEVEL  = 3,
    parameter int NUM_SLICES = 4
) (
    input  logic                                         cclk,
    input  logic                                         crst_n,
    input  logic                                         start,
    input  logic                                         abort,
    input  logic                                         bit_valid,
    input  logic                                         bit_in,
    output logic                                         bit_ready,
    output logic [cfg_width(MUX_LEVEL, NUM_SLICES)-1:0] cfg_out,
    output logic                                         cen,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         err
);

    localparam int CFG_W = cfg_width(MUX_LEVEL, NUM_SLICES);

    state_t           state;
    state_t           state_nxt;
    logic             clear;
    logic             shift;
    logic             commit;
    logic             abort_hit;
    logic             full_on_shift;
    logic [CFG_W-1:0] next_word;

    mux_f_cfg_shifter #(
        .CFG_W(CFG_W)
    ) u_shifter (
        .clk          (cclk),
        .rst_n        (crst_n),
        .clear        (clear),
        .shift        (shift),
        .bit_in       (bit_in),
        .next_word    (next_word),
        .full_on_shift(full_on_shift)
    );

    // Abort takes priority over the accept, so an abort coinciding with the
    // final bit neither shifts nor commits.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        shift     = 1'b0;
        commit    = 1'b0;
        abort_hit = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (bit_valid) begin
                    shift = 1'b1;
                    if (full_on_shift) begin
                        commit    = 1'b1;
                        state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP:  state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_HOLD;
            ST_HOLD:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n) begin
            state   <= ST_IDLE;
            err     <= 1'b0;
            cfg_out <= '0;
        end else begin
            state <= state_nxt;
            err   <= abort_hit;
            if (commit) begin
                cfg_out <= next_word;
            end
        end
    end

    // Remaining outputs decode straight from state, so none follow the inputs.
    assign bit_ready = (state == ST_LOAD);
    assign cen       = (state == ST_COMMIT);
    assign done      = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

endmodule
